// File: rtl/qr_sched_pkg.sv
// Shared types and defaults for the QR core matrix scheduler.
package qr_sched_pkg;

   localparam int unsigned DEF_DW   = 13;
   localparam int unsigned DEF_NCOL = 4;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      BURST = 2'd1,
      WAIT  = 2'd2
   } state_e;

   typedef logic signed [DEF_NCOL-1:0][DEF_DW-1:0] row_t;

endpackage

// File: rtl/qr_row_buf.sv
// Single-matrix row store: one synchronous write port, one combinational read port.
module qr_row_buf #(
   parameter int unsigned W     = 52,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata_c
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/qr_matrix_sched.sv
// Buffers one matrix from the upstream stream, bursts it into the QR core, forwards results.
// Optional WAIT-state watchdog enabled by defining QR_SCHED_TIMEOUT_EN.
module qr_matrix_sched
   import qr_sched_pkg::*;
#(
`ifdef QR_SCHED_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC = 64,
`endif
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned NCOL     = DEF_NCOL,
   parameter int unsigned ROWS     = 8,
   parameter int unsigned OUT_ROWS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NCOL*DW-1:0] in_row,
   input  logic               in_last,
   output logic [DW-1:0]      core_data_inA,
   output logic [DW-1:0]      core_data_inB,
   output logic [DW-1:0]      core_data_inC,
   output logic [DW-1:0]      core_data_inD,
   output logic               core_last_end,
   input  logic               core_valid,
   input  logic [DW-1:0]      core_data_outA,
   input  logic [DW-1:0]      core_data_outB,
   input  logic [DW-1:0]      core_data_outC,
   input  logic [DW-1:0]      core_data_outD,
   input  logic               core_finish_out,
   output logic               out_valid,
   output logic [NCOL*DW-1:0] out_row,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int unsigned RW = NCOL * DW;
   localparam int unsigned AW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = $clog2(OUT_ROWS + 1);
`ifdef QR_SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_to_cnt, w_to_cnt;
`endif

   state_e                   r_state, w_state;
   logic [AW-1:0]            r_wr_cnt, w_wr_cnt;
   logic [AW-1:0]            r_rd_ptr, w_rd_ptr;
   logic [CW-1:0]            r_rd_cnt, w_rd_cnt;
   logic [NCOL-1:0][DW-1:0]  r_core_row, w_core_row;
   logic [RW-1:0]            w_rdata;
   logic [RW-1:0]            w_out_row;
   logic                     w_we, w_hs, w_last, w_out_valid, w_done, w_err;
   logic                     w_in_ready, w_busy;

   qr_row_buf #(.W(RW), .DEPTH(ROWS), .AW(AW)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .i_we      (w_we),
      .i_waddr   (r_wr_cnt),
      .i_wdata   (in_row),
      .i_raddr   (r_rd_ptr),
      .o_rdata_c (w_rdata)
   );

   assign w_hs = (r_state == FILL) && in_valid && in_ready;

   // Next-state and next-output logic
   always_comb begin
      w_state     = r_state;
      w_wr_cnt    = r_wr_cnt;
      w_rd_ptr    = r_rd_ptr;
      w_rd_cnt    = r_rd_cnt;
      w_core_row  = '0;
      w_last      = 1'b0;
      w_out_valid = 1'b0;
      w_out_row   = out_row;
      w_done      = 1'b0;
      w_err       = err;
      w_we        = 1'b0;
`ifdef QR_SCHED_TIMEOUT_EN
      w_to_cnt    = r_to_cnt;
`endif
      case (r_state)
         FILL: begin
            if (w_hs) begin
               w_we = 1'b1;
               if (in_last && (r_wr_cnt == AW'(ROWS - 1))) begin
                  w_state  = BURST;
                  w_wr_cnt = '0;
               end else if (in_last || (r_wr_cnt == AW'(ROWS - 1))) begin
                  w_err    = 1'b1;
                  w_wr_cnt = '0;
               end else begin
                  w_wr_cnt = r_wr_cnt + AW'(1);
               end
            end
         end
         BURST: begin
            w_core_row = w_rdata;
            w_last     = (r_rd_ptr == AW'(ROWS - 1));
            if (w_last) begin
               w_state  = WAIT;
               w_rd_ptr = '0;
`ifdef QR_SCHED_TIMEOUT_EN
               w_to_cnt = '0;
`endif
            end else begin
               w_rd_ptr = r_rd_ptr + AW'(1);
            end
         end
         WAIT: begin
            if (core_valid) begin
               if (r_rd_cnt < CW'(OUT_ROWS)) begin
                  w_out_valid = 1'b1;
                  w_out_row   = {core_data_outD, core_data_outC, core_data_outB, core_data_outA};
                  w_rd_cnt    = r_rd_cnt + CW'(1);
               end else begin
                  w_err = 1'b1;
               end
            end
            // A row arriving alongside finish is counted before the completeness check
            if (core_finish_out) begin
               w_done   = 1'b1;
               if (w_rd_cnt != CW'(OUT_ROWS)) w_err = 1'b1;
               w_rd_cnt = '0;
               w_state  = FILL;
`ifdef QR_SCHED_TIMEOUT_EN
            end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
               w_done   = 1'b1;
               w_err    = 1'b1;
               w_rd_cnt = '0;
               w_state  = FILL;
            end else begin
               w_to_cnt = r_to_cnt + TW'(1);
`endif
            end
         end
         default: w_state = FILL;
      endcase
      w_in_ready = (w_state == FILL);
      w_busy     = (w_state != FILL) || (w_wr_cnt != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= FILL;
         r_wr_cnt      <= '0;
         r_rd_ptr      <= '0;
         r_rd_cnt      <= '0;
         r_core_row    <= '0;
         core_last_end <= 1'b0;
         in_ready      <= 1'b0;
         out_valid     <= 1'b0;
         out_row       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
`ifdef QR_SCHED_TIMEOUT_EN
         r_to_cnt      <= '0;
`endif
      end else begin
         r_state       <= w_state;
         r_wr_cnt      <= w_wr_cnt;
         r_rd_ptr      <= w_rd_ptr;
         r_rd_cnt      <= w_rd_cnt;
         r_core_row    <= w_core_row;
         core_last_end <= w_last;
         in_ready      <= w_in_ready;
         out_valid     <= w_out_valid;
         out_row       <= w_out_row;
         busy          <= w_busy;
         done          <= w_done;
         err           <= w_err;
`ifdef QR_SCHED_TIMEOUT_EN
         r_to_cnt      <= w_to_cnt;
`endif
      end
   end

   assign core_data_inA = r_core_row[0];
   assign core_data_inB = r_core_row[1];
   assign core_data_inC = r_core_row[2];
   assign core_data_inD = r_core_row[3];

endmodule

// File: tb/tb_qr_matrix_sched.sv
// Directed bench for qr_matrix_sched: fill/burst/result forwarding, framing errors, async reset.
module tb_qr_matrix_sched;

   localparam int DW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_last, in_ready;
   logic [51:0]   in_row;
   logic [DW-1:0] core_data_inA, core_data_inB, core_data_inC, core_data_inD;
   logic          core_last_end;
   logic          core_valid, core_finish_out;
   logic [DW-1:0] core_data_outA, core_data_outB, core_data_outC, core_data_outD;
   logic          out_valid, busy, done, err;
   logic [51:0]   out_row;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] in_rows [8][4];
   logic [DW-1:0] resp    [8][4];

   qr_matrix_sched dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_row          (in_row),
      .in_last         (in_last),
      .core_data_inA   (core_data_inA),
      .core_data_inB   (core_data_inB),
      .core_data_inC   (core_data_inC),
      .core_data_inD   (core_data_inD),
      .core_last_end   (core_last_end),
      .core_valid      (core_valid),
      .core_data_outA  (core_data_outA),
      .core_data_outB  (core_data_outB),
      .core_data_outC  (core_data_outC),
      .core_data_outD  (core_data_outD),
      .core_finish_out (core_finish_out),
      .out_valid       (out_valid),
      .out_row         (out_row),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [51:0] pack_in(input int r);
      return {in_rows[r][3], in_rows[r][2], in_rows[r][1], in_rows[r][0]};
   endfunction

   function automatic logic [51:0] pack_resp(input int r);
      return {resp[r][3], resp[r][2], resp[r][1], resp[r][0]};
   endfunction

   // Sends rows 0..nrows-1; in_last on the final one; ends right after its accept edge
   task automatic send_matrix(input bit gaps, input int nrows);
      for (int r = 0; r < nrows; r++) begin
         if (gaps && r > 0) begin
            in_valid = 1'b0;
            tick();
         end
         chk("in_ready_fill", 64'(in_ready), 64'(1));
         in_valid = 1'b1;
         in_row   = pack_in(r);
         in_last  = (r == nrows - 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_burst();
      chk("in_ready_after_last", 64'(in_ready), 64'(0));
      chk("busy_after_last", 64'(busy), 64'(1));
      for (int r = 0; r < 8; r++) begin
         tick();
         chk("core_row", {core_data_inD, core_data_inC, core_data_inB, core_data_inA}, pack_in(r));
         chk("core_last_end", 64'(core_last_end), 64'(r == 7));
         chk("in_ready_burst", 64'(in_ready), 64'(0));
      end
      tick();
      chk("core_row_idle", {core_data_inD, core_data_inC, core_data_inB, core_data_inA}, 64'(0));
      chk("core_last_end_idle", 64'(core_last_end), 64'(0));
   endtask

   task automatic core_respond(input int nvalid, input bit same_cycle, input logic exp_err);
      for (int i = 0; i < nvalid; i++) begin
         core_valid     = 1'b1;
         core_data_outA = resp[i][0];
         core_data_outB = resp[i][1];
         core_data_outC = resp[i][2];
         core_data_outD = resp[i][3];
         core_finish_out = same_cycle && (i == nvalid - 1);
         tick();
         chk("out_valid", 64'(out_valid), 64'(1));
         chk("out_row", 64'(out_row), 64'(pack_resp(i)));
         chk("in_ready_wait", 64'(in_ready), 64'(core_finish_out));
      end
      if (!same_cycle) begin
         core_valid      = 1'b0;
         core_finish_out = 1'b1;
         tick();
         chk("out_valid_fin", 64'(out_valid), 64'(0));
      end
      chk("done_pulse", 64'(done), 64'(1));
      chk("err_at_done", 64'(err), 64'(exp_err));
      chk("in_ready_after_done", 64'(in_ready), 64'(1));
      chk("busy_after_done", 64'(busy), 64'(0));
      core_valid      = 1'b0;
      core_finish_out = 1'b0;
      tick();
      chk("done_once", 64'(done), 64'(0));
   endtask

   initial begin
      for (int r = 0; r < 8; r++)
         for (int l = 0; l < 4; l++)
            in_rows[r][l] = DW'(4 * r + l + 1);
      resp[0] = '{13'h1000, 13'h0FFF, 13'h0000, 13'h1FFF};   // -4096, 4095, 0, -1
      resp[1] = '{13'h0FFF, 13'h1000, 13'h1FFF, 13'h0001};
      resp[2] = '{13'h0123, 13'h1ABC, 13'h0456, 13'h1DEF};
      resp[3] = '{13'h0007, 13'h0070, 13'h0700, 13'h1007};
      resp[4] = '{13'h1555, 13'h0AAA, 13'h1555, 13'h0AAA};
      resp[5] = '{13'h0010, 13'h0020, 13'h0030, 13'h0040};
      resp[6] = '{13'h1F00, 13'h00FF, 13'h1800, 13'h07FF};
      resp[7] = '{13'h0FFF, 13'h0FFF, 13'h1000, 13'h1000};

      reset = 1'b0;
      in_valid = 1'b0; in_last = 1'b0; in_row = '0;
      core_valid = 1'b0; core_finish_out = 1'b0;
      core_data_outA = '0; core_data_outB = '0; core_data_outC = '0; core_data_outD = '0;
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_row", 64'(out_row), 64'(0));
      chk("rst_core_last", 64'(core_last_end), 64'(0));
      chk("rst_core_row", {core_data_inD, core_data_inC, core_data_inB, core_data_inA}, 64'(0));
      tick();
      tick();
      reset = 1'b1;
      chk("in_ready_before_edge", 64'(in_ready), 64'(0));
      tick();
      chk("in_ready_first_edge", 64'(in_ready), 64'(1));

      // Contiguous matrix, full response, finish in separate cycle
      send_matrix(1'b0, 8);
      check_burst();
      core_respond(8, 1'b0, 1'b0);

      // Gapped upstream, last result row coincides with finish
      send_matrix(1'b1, 8);
      check_burst();
      core_respond(8, 1'b1, 1'b0);

      // Early in_last on row 5
      send_matrix(1'b0, 5);
      chk("early_last_err", 64'(err), 64'(1));
      chk("early_last_ready", 64'(in_ready), 64'(1));
      chk("early_last_busy", 64'(busy), 64'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("early_last_no_core", {core_data_inD, core_data_inC, core_data_inB, core_data_inA, 11'(0), core_last_end}, 64'(0));
      end
      send_matrix(1'b0, 8);
      check_burst();
      core_respond(8, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a burst
      send_matrix(1'b0, 8);
      for (int r = 0; r < 3; r++) begin
         tick();
         chk("mid_burst_row", {core_data_inD, core_data_inC, core_data_inB, core_data_inA}, pack_in(r));
      end
      reset = 1'b0;
      #1;
      chk("async_core_row", {core_data_inD, core_data_inC, core_data_inB, core_data_inA}, 64'(0));
      chk("async_in_ready", 64'(in_ready), 64'(0));
      chk("async_busy", 64'(busy), 64'(0));
      chk("async_err", 64'(err), 64'(0));
      #3;
      reset = 1'b1;
      tick();
      chk("post_reset_ready", 64'(in_ready), 64'(1));

      // Finish after only 6 result rows
      send_matrix(1'b0, 8);
      check_burst();
      core_respond(6, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
